// File: rtl/mc_bus_master.sv
// Burst master for a multiplexed address/data bus: one address beat, then a
// four-word write burst or a turnaround cycle followed by a four-word read burst.
module mc_bus_master #(
   parameter int DATA_W = 16,
   parameter int BURST  = 4
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_rw,
   input  logic [DATA_W-1:0]        cmd_addr,
   input  logic [DATA_W*BURST-1:0]  cmd_wdata,
   output logic [DATA_W*BURST-1:0]  rd_data,
   output logic                     done,
   output logic                     AddrValid,
   output logic                     rw,
   output logic [DATA_W-1:0]        AddrData_out,
   output logic                     AddrData_oe,
   input  logic [DATA_W-1:0]        AddrData_in
);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, TURN, RDATA, FIN} state_t;

   localparam logic [1:0] LAST_BEAT = 2'(BURST - 1);

   state_t                    state;
   logic [1:0]                beat;
   logic [DATA_W*BURST-1:0]   wdata_q;

   function automatic logic [DATA_W-1:0] word_at(input logic [DATA_W*BURST-1:0] v,
                                                 input logic [1:0] k);
      return v[int'(k)*DATA_W +: DATA_W];
   endfunction

   // Every bus output is registered: each branch sets the values for the state being entered.
   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         beat         <= '0;
         wdata_q      <= '0;
         cmd_ready    <= 1'b0;
         done         <= 1'b0;
         AddrValid    <= 1'b0;
         rw           <= 1'b0;
         AddrData_oe  <= 1'b0;
         AddrData_out <= '0;
         rd_data      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state        <= ADDR;
                  cmd_ready    <= 1'b0;
                  wdata_q      <= cmd_wdata;
                  rw           <= cmd_rw;
                  AddrValid    <= 1'b1;
                  AddrData_oe  <= 1'b1;
                  AddrData_out <= cmd_addr;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            ADDR: begin
               AddrValid <= 1'b0;
               beat      <= '0;
               if (rw) begin
                  state        <= TURN;
                  AddrData_oe  <= 1'b0;
                  AddrData_out <= '0;
               end else begin
                  state        <= WDATA;
                  AddrData_out <= word_at(wdata_q, 2'd0);
               end
            end
            WDATA: begin
               beat <= beat + 2'd1;
               if (beat == LAST_BEAT) begin
                  state        <= FIN;
                  done         <= 1'b1;
                  AddrData_oe  <= 1'b0;
                  AddrData_out <= '0;
               end else begin
                  AddrData_out <= word_at(wdata_q, beat + 2'd1);
               end
            end
            TURN: begin
               state <= RDATA;
               beat  <= '0;
            end
            RDATA: begin
               rd_data[int'(beat)*DATA_W +: DATA_W] <= AddrData_in;
               beat <= beat + 2'd1;
               if (beat == LAST_BEAT) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state     <= IDLE;
               done      <= 1'b0;
               rw        <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               done         <= 1'b0;
               AddrValid    <= 1'b0;
               AddrData_oe  <= 1'b0;
               AddrData_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_bus_master.sv
// Self-checking bench for mc_bus_master: directed and random bursts compared
// cycle by cycle against a transaction-level model of the bus protocol.
module tb_mc_bus_master;

   logic        clk = 1'b0;
   logic        resetN;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rw;
   logic [15:0] cmd_addr;
   logic [63:0] cmd_wdata;
   logic [63:0] rd_data;
   logic        done;
   logic        AddrValid;
   logic        rw;
   logic [15:0] AddrData_out;
   logic        AddrData_oe;
   logic [15:0] AddrData_in;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_rd   = '0;

   always #5 clk = ~clk;

   mc_bus_master #(.DATA_W(16), .BURST(4)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rd_data      (rd_data),
      .done         (done),
      .AddrValid    (AddrValid),
      .rw           (rw),
      .AddrData_out (AddrData_out),
      .AddrData_oe  (AddrData_oe),
      .AddrData_in  (AddrData_in)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 64'(cmd_ready), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
      check({tag, "_av"},    64'(AddrValid), 64'd0);
      check({tag, "_rw"},    64'(rw), 64'd0);
      check({tag, "_oe"},    64'(AddrData_oe), 64'd0);
      check({tag, "_out"},   64'(AddrData_out), 64'd0);
      check({tag, "_rd"},    rd_data, 64'd0);
   endtask

   // One whole transaction: the expected bus trace comes from the protocol rules
   // (address beat, four write words or turnaround plus four read words, completion).
   task automatic run_cmd(input logic r, input logic [15:0] addr, input logic [63:0] wd,
                          input logic [63:0] rdw, input bit hold);
      int          n;
      logic        e_av, e_oe, e_done;
      logic [15:0] e_out;
      n = r ? 7 : 6;
      @(negedge clk);
      check("ready_in_idle", 64'(cmd_ready), 64'd1);
      cmd_valid   = 1'b1;
      cmd_rw      = r;
      cmd_addr    = addr;
      cmd_wdata   = wd;
      AddrData_in = 16'($urandom);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         e_av   = (c == 1);
         e_done = (c == n);
         e_oe   = (c == 1) || (!r && c >= 2 && c <= 5);
         if (c == 1)                     e_out = addr;
         else if (!r && c >= 2 && c <= 5) e_out = wd[(c-2)*16 +: 16];
         else                            e_out = 16'd0;
         check("addr_valid", 64'(AddrValid), 64'(e_av));
         check("oe",         64'(AddrData_oe), 64'(e_oe));
         check("bus_out",    64'(AddrData_out), 64'(e_out));
         check("done",       64'(done), 64'(e_done));
         check("ready_busy", 64'(cmd_ready), 64'd0);
         if (c < n) check("rw", 64'(rw), 64'(r));
         if (r && c == n) exp_rd = rdw;
         if (!r || c == n) check("rd_data", rd_data, exp_rd);
         if (r && c >= 3 && c <= 6) begin
            check("oe_while_mem_drives", 64'(AddrData_oe), 64'd0);
            AddrData_in = rdw[(c-3)*16 +: 16];
         end else begin
            AddrData_in = 16'($urandom);
         end
         cmd_rw    = 1'($urandom);
         cmd_addr  = 16'($urandom);
         cmd_wdata = {$urandom, $urandom};
         if (c == n) cmd_valid = hold;
         else        cmd_valid = hold ? 1'b1 : 1'($urandom);
      end
   endtask

   initial begin
      logic        r;
      logic [15:0] a;
      logic [63:0] wd, rdw;

      resetN      = 1'b0;
      cmd_valid   = 1'b0;
      cmd_rw      = 1'b0;
      cmd_addr    = '0;
      cmd_wdata   = '0;
      AddrData_in = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      #1 check("ready_after_release", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      check("ready_first_clock", 64'(cmd_ready), 64'd1);

      run_cmd(1'b0, 16'h2010, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 64'd0, 1'b0);
      run_cmd(1'b1, 16'h2020, 64'd0, {16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0}, 1'b0);
      run_cmd(1'b0, 16'h3000, {16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF0F0}, 64'd0, 1'b0);

      // cmd_valid held high across three back-to-back commands
      run_cmd(1'b0, 16'h4100, {$urandom, $urandom}, 64'd0, 1'b1);
      run_cmd(1'b1, 16'h4200, 64'd0, {$urandom, $urandom}, 1'b1);
      run_cmd(1'b0, 16'h4300, {$urandom, $urandom}, 64'd0, 1'b0);

      // reset in the second write-data cycle aborts the burst
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rw    = 1'b0;
      cmd_addr  = 16'h5000;
      cmd_wdata = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      check("abort_oe_before", 64'(AddrData_oe), 64'd1);
      #2 resetN = 1'b0;
      exp_rd    = '0;
      #1 check_all_zero("abort");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 64'(done), 64'd0);
      end
      resetN = 1'b1;
      @(negedge clk);
      check("ready_after_abort", 64'(cmd_ready), 64'd1);
      run_cmd(1'b1, 16'h6000, 64'd0, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 1'b0);

      for (int i = 0; i < 8; i++) begin
         r   = 1'($urandom);
         a   = 16'($urandom);
         wd  = {$urandom, $urandom};
         rdw = {$urandom, $urandom};
         run_cmd(r, a, wd, rdw, 1'($urandom) && (i < 7));
      end

      @(negedge clk);
      check("final_idle_ready", 64'(cmd_ready), 64'd1);
      check("final_rd_hold", rd_data, exp_rd);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_bus_master.md
MC_BUS_MASTER -- requirements
Module: mc_bus_master

Interface
REQ-001 Parameter: DATA_W, default 16, width of one main-bus word and of the multiplexed address/data path.
REQ-002 Parameter: BURST, default 4, number of data words per bus transaction; fixed at 4 for this release.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: resetN  input  1  asynchronous, active-low reset.
REQ-005 Port: cmd_valid  input  1  requester presents a transaction.
REQ-006 Port: cmd_ready  output  1  master can accept a command this cycle.
REQ-007 Port: cmd_rw  input  1  1 = read burst, 0 = write burst.
REQ-008 Port: cmd_addr  input  DATA_W  burst base address; bits [15:12] select the memory page.
REQ-009 Port: cmd_wdata  input  DATA_W*BURST  write words; word k in bits [16k+15:16k].
REQ-010 Port: rd_data  output  DATA_W*BURST  assembled read burst, same word packing as cmd_wdata.
REQ-011 Port: done  output  1  one-cycle pulse at transaction completion.
REQ-012 Port: AddrValid  output  1  address-phase strobe on the main bus.
REQ-013 Port: rw  output  1  bus direction qualifier; 1 = read.
REQ-014 Port: AddrData_out  output  DATA_W  value driven onto the shared address/data lines.
REQ-015 Port: AddrData_oe  output  1  1 = master drives AddrData_out onto the bus.
REQ-016 Port: AddrData_in  input  DATA_W  sampled bus value driven by the memory controller.

Function
REQ-017 States SHALL be IDLE, ADDR, WDATA, TURN, RDATA, FIN; a 2-bit beat counter indexes words 0..3.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready at posedge clk.
REQ-019 On acceptance, the master SHALL register cmd_rw, cmd_addr, and cmd_wdata, and enter ADDR; inputs are ignored until the return to IDLE.
REQ-020 ADDR (one cycle): AddrValid=1, AddrData_oe=1, AddrData_out=captured address, rw=captured cmd_rw.
REQ-021 Write: ADDR -> WDATA for exactly 4 cycles, driving AddrData_out=word 0,1,2,3 in order with AddrData_oe=1, AddrValid=0, and rw=0; then FIN.
REQ-022 Read: ADDR -> TURN (one cycle, AddrData_oe=0) -> RDATA for exactly 4 cycles, sampling AddrData_in into rd_data words 0,1,2,3 in order; then FIN.
REQ-023 During TURN and RDATA, AddrData_oe SHALL be 0 and rw SHALL remain 1.
REQ-024 FIN (one cycle): done=1, AddrData_oe=0, AddrValid=0; next state IDLE.
REQ-025 Latency: a write completes with done 6 cycles after acceptance; a read completes with done 7 cycles after acceptance.
REQ-026 Beat counter SHALL wrap 3->0 on the last beat; no address increment is generated by the master (the memory controller increments within the burst).
REQ-027 rd_data SHALL hold its last assembled value until the next read burst overwrites it; write bursts SHALL NOT alter rd_data.
REQ-028 Back-to-back operation: cmd_ready SHALL be asserted in the IDLE cycle following FIN; there are no bus-idle cycles besides FIN and IDLE.
REQ-029 AddrData_out SHALL be 0 whenever AddrData_oe=0.
REQ-030 AddrValid SHALL never be 1 outside ADDR, and SHALL be 1 for exactly one cycle per accepted command.

Reset
REQ-031 On resetN=0, asynchronously: state=IDLE, counter=0, cmd_ready=0, done=0, AddrValid=0, rw=0, AddrData_oe=0, AddrData_out=0, rd_data=0.
REQ-032 cmd_ready SHALL rise in the first clock after resetN deasserts.
REQ-033 Reset mid-burst SHALL abort the transaction: no done pulse is generated and the bus is released immediately.

Verification
REQ-034 Write addr 16'h2010, wdata {16'h4444,16'h3333,16'h2222,16'h1111} -> AddrValid for 1 cycle with 16'h2010 and rw=0, then bus shows 1111, 2222, 3333, 4444, then done at acceptance+6.
REQ-035 Read addr 16'h2020 with the memory model driving A5A0..A5A3 in the RDATA cycles -> TURN with oe=0, then rd_data=={A5A3,A5A2,A5A1,A5A0} and done at acceptance+7.
REQ-036 cmd_valid held high for 3 consecutive commands (W, R, W) -> each is accepted only in IDLE, each has exactly one AddrValid pulse, and no bus conflict occurs (oe=0 whenever the memory model drives).
REQ-037 resetN asserted in the 2nd WDATA cycle -> all outputs are 0 within the same cycle, no done pulse, and the next command after release runs normally.
REQ-038 Write burst after a read -> rd_data is unchanged and AddrData_out is 0 in all oe=0 cycles.
